// File: rtl/l1_sram_block_array.sv
// l1_sram_block_array
//   Block-organised data store for the L1 cache. Each (way, word) pair is its
//   own 32-bit wide RAM with byte write enables, so a single access can write
//   any subset of words/bytes of one block or read a whole block. After reset
//   an init sequencer zeroes one set (all ways) per cycle before requests are
//   accepted. Read data is delayed by READ_LATENCY edges through a pipeline.
//
// Ports
//   CLK         clock
//   nRST        asynchronous active-low reset
//   req_valid   request present
//   req_ready   request accepted on this edge when req_valid is also high
//   req_write   1 = write, 0 = read
//   set_bits    set index (out-of-range sets drop writes, read back as zero)
//   frame_bits  way index (out-of-range ways handled like out-of-range sets)
//   word_mask   per-word write enable
//   byte_en     byte enable, shared by every masked word
//   wdata       write block, word i in bits [32i+31:32i]
//   rsp_valid   read response valid, one cycle per accepted read
//   rdata       read block, zero whenever rsp_valid is low
//   busy        inverse of req_ready
module l1_sram_block_array #(
  parameter int ASSOC        = 2,
  parameter int N_SETS       = 64,
  parameter int N_SET_BITS   = 6,
  parameter int N_FRAME_BITS = 1,
  parameter int BLOCK_SIZE   = 4,
  parameter int READ_LATENCY = 1
) (
  input  logic                       CLK,
  input  logic                       nRST,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_write,
  input  logic [N_SET_BITS-1:0]      set_bits,
  input  logic [N_FRAME_BITS-1:0]    frame_bits,
  input  logic [BLOCK_SIZE-1:0]      word_mask,
  input  logic [3:0]                 byte_en,
  input  logic [BLOCK_SIZE*32-1:0]   wdata,
  output logic                       rsp_valid,
  output logic [BLOCK_SIZE*32-1:0]   rdata,
  output logic                       busy
);

  localparam int BLK_W    = BLOCK_SIZE * 32;
  localparam int SET_AW   = (N_SETS > 1) ? $clog2(N_SETS) : 1;
  localparam int FRAME_AW = (ASSOC > 1) ? $clog2(ASSOC) : 1;
  localparam int N_BANKS  = ASSOC * BLOCK_SIZE;

  localparam logic [31:0]       N_SETS_U = 32'(N_SETS);
  localparam logic [31:0]       ASSOC_U  = 32'(ASSOC);
  localparam logic [SET_AW-1:0] LAST_SET = SET_AW'(N_SETS - 1);

  typedef enum logic {INIT, READY} state_t;

  state_t              state_reg, state_next;
  logic [SET_AW-1:0]   init_cnt_reg, init_cnt_next;

  logic                init_active;
  logic                accept;
  logic                in_range;
  logic                wr_accept;
  logic                rd_accept;
  logic [SET_AW-1:0]   set_idx;
  logic [FRAME_AW-1:0] frame_idx;
  logic [SET_AW-1:0]   wr_addr;

  logic [N_BANKS*32-1:0]   bank_rdata;
  logic [FRAME_AW-1:0]     rd_frame_reg;
  logic [BLK_W-1:0]        rd_block;
  logic [BLK_W-1:0]        out_block;
  logic [READ_LATENCY-1:0] pipe_valid_reg;
  logic [READ_LATENCY-1:0] pipe_ok_reg;

  // ---------------------------------------------------------------------------
  // Init sequencer / request acceptance
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_reg    <= INIT;
      init_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      init_cnt_reg <= init_cnt_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    init_cnt_next = init_cnt_reg;
    req_ready     = 1'b0;
    case (state_reg)
      INIT: begin
        if (init_cnt_reg == LAST_SET) begin
          state_next = READY;
        end else begin
          init_cnt_next = init_cnt_reg + SET_AW'(1);
        end
      end
      READY: begin
        req_ready = 1'b1;
      end
      default: begin
        state_next = INIT;
      end
    endcase
  end

  assign busy        = ~req_ready;
  assign init_active = (state_reg == INIT);
  assign accept      = req_valid & req_ready;

  // Range check uses the full-width index; the truncated indices below are
  // only ever used for accesses already qualified by in_range.
  assign in_range  = (32'(set_bits) < N_SETS_U) && (32'(frame_bits) < ASSOC_U);
  assign set_idx   = set_bits[SET_AW-1:0];
  assign frame_idx = frame_bits[FRAME_AW-1:0];
  assign wr_accept = accept & req_write & in_range;
  assign rd_accept = accept & ~req_write;
  assign wr_addr   = init_active ? init_cnt_reg : set_idx;

  // ---------------------------------------------------------------------------
  // Storage: one RAM per (way, word), bank index = way * BLOCK_SIZE + word
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < N_BANKS; gi++) begin : g_bank
      localparam int WAY  = gi / BLOCK_SIZE;
      localparam int WORD = gi % BLOCK_SIZE;

      logic [31:0] mem [N_SETS];
      logic [31:0] rd_word_reg;
      logic [3:0]  bank_we;
      logic [31:0] bank_wd;

      // During INIT every bank writes zero to the current set, so a whole set
      // (all ways, all words) is cleared per cycle.
      always_comb begin
        bank_we = 4'h0;
        bank_wd = wdata[32*WORD +: 32];
        if (init_active) begin
          bank_we = 4'hF;
          bank_wd = '0;
        end else if (wr_accept && (frame_idx == FRAME_AW'(WAY)) && word_mask[WORD]) begin
          bank_we = byte_en;
        end
      end

      // Read-before-write is never an issue: a read accepted one edge after a
      // write sees the array already updated by that earlier edge.
      always_ff @(posedge CLK) begin
        for (int b = 0; b < 4; b++) begin
          if (bank_we[b]) begin
            mem[wr_addr][8*b +: 8] <= bank_wd[8*b +: 8];
          end
        end
        if (rd_accept) begin
          rd_word_reg <= mem[set_idx];
        end
      end

      assign bank_rdata[32*gi +: 32] = rd_word_reg;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Read path: way select after the RAM stage, then optional extra delay
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      rd_frame_reg <= '0;
    end else if (rd_accept) begin
      rd_frame_reg <= frame_idx;
    end
  end

  always_comb begin
    rd_block = '0;
    for (int w = 0; w < ASSOC; w++) begin
      if (rd_frame_reg == FRAME_AW'(w)) begin
        rd_block = bank_rdata[w*BLK_W +: BLK_W];
      end
    end
  end

  // Valid and in-range flags travel with the read; bit 0 is the RAM stage.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      pipe_valid_reg <= '0;
      pipe_ok_reg    <= '0;
    end else begin
      pipe_valid_reg[0] <= rd_accept;
      pipe_ok_reg[0]    <= in_range;
      for (int k = 1; k < READ_LATENCY; k++) begin
        pipe_valid_reg[k] <= pipe_valid_reg[k-1];
        pipe_ok_reg[k]    <= pipe_ok_reg[k-1];
      end
    end
  end

  generate
    if (READ_LATENCY == 1) begin : g_lat1
      assign out_block = rd_block;
    end else begin : g_latn
      logic [BLK_W-1:0] dly_reg [READ_LATENCY-1];

      always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
          for (int k = 0; k < READ_LATENCY - 1; k++) begin
            dly_reg[k] <= '0;
          end
        end else begin
          dly_reg[0] <= rd_block;
          for (int k = 1; k < READ_LATENCY - 1; k++) begin
            dly_reg[k] <= dly_reg[k-1];
          end
        end
      end

      assign out_block = dly_reg[READ_LATENCY-2];
    end
  endgenerate

  assign rsp_valid = pipe_valid_reg[READ_LATENCY-1];
  assign rdata     = (rsp_valid && pipe_ok_reg[READ_LATENCY-1]) ? out_block : '0;

endmodule

// File: doc/l1_sram_block_array.md
# l1_sram_block_array

Parametrised, pipelined synchronous SRAM model for L1 cache data storage, generalising the single-word-write data array: full-block or masked-word writes with byte enables, configurable read latency, and a valid/ready request handshake. On reset it zeroes every entry with an internal init sequencer. It sits between the L1 cache controller and the data storage, and is used in both SRAM-macro and flip-flop (verification) builds.

## Interface
- ASSOC, 2: ways per set (≥1)
- N_SETS, 64: sets (≥2; need not be a power of 2)
- N_SET_BITS, 6: width of set index, ≥ $clog2(N_SETS)
- N_FRAME_BITS, 1: width of way index, ≥ max(1, $clog2(ASSOC))
- BLOCK_SIZE, 4: 32-bit words per block (power of 2, 1..16)
- READ_LATENCY, 1: edges from acceptance to response (1..3)
- CLK  in  1  clock
- nRST  in  1  reset; one clock; reset is asynchronous and active-low
- req_valid  in  1  request present
- req_ready  out  1  request can be accepted this cycle
- req_write  in  1  1 = write, 0 = read
- set_bits  in  N_SET_BITS  set index
- frame_bits  in  N_FRAME_BITS  way index
- word_mask  in  BLOCK_SIZE  per-word write enable
- byte_en  in  4  byte enable, applied to every masked word
- wdata  in  BLOCK_SIZE×32  write block; word i → word i
- rsp_valid  out  1  read data valid
- rdata  out  BLOCK_SIZE×32  read block
- busy  out  1  equals ~req_ready

## Operation
- States: INIT, READY. Reset (async) → INIT, init counter = 0, read pipeline cleared.
- INIT: each cycle zero all ASSOC ways of set[counter], counter++; after set N_SETS-1 is cleared → READY. req_ready = 0 throughout.
- READY: req_ready = 1; exactly one request is accepted per edge where req_valid && req_ready.
- Write: for each word i with word_mask[i]=1, bytes b with byte_en[b]=1 get wdata[i][8b+7:8b]; all other bytes unchanged. Writes produce no response. word_mask = 0 or byte_en = 0 → no change.
- Read: whole block [set][frame] returned; word_mask/byte_en/wdata ignored.
- Ordering: a read observes every write accepted on an earlier edge, including the immediately preceding one (no stale data).
- Out of range: set_bits ≥ N_SETS → write dropped; read still responds, rdata = 0. frame_bits ≥ ASSOC handled identically.
- rdata = 0 whenever rsp_valid = 0.
- Reset asserted mid-operation: in-flight reads discarded (no rsp_valid), INIT restarts from set 0, and all contents are zeroed again.

## Timing
- Reset values: req_ready 0, busy 1, rsp_valid 0, rdata 0.
- INIT lasts exactly N_SETS cycles: req_ready rises in the cycle after the N_SETS-th rising edge following nRST deassertion.
- Read accepted on edge E: rsp_valid = 1 and rdata valid during the cycle after edge E+READ_LATENCY-1 (L=1: cycle immediately after E), for exactly one cycle per read.
- Fully pipelined: back-to-back reads give back-to-back rsp_valid in request order; reads and writes may interleave every cycle.
- No response backpressure; the consumer must sink rsp every cycle.
- Write accepted on edge E is architecturally visible to a read accepted on edge E+1.

## Test plan
- Reset, N_SETS=64: req_ready=0 for 64 cycles, then 1; read of set 63 way 1 returns all-zero block, rsp_valid exactly one cycle.
- Full-block write set 5 way 0 with wdata {0x44444444,0x33333333,0x22222222,0x11111111}, mask 4'b1111, byte_en 4'b1111; read on next edge returns the same block (no stale data).
- Masked write to that block: mask 4'b0010, byte_en 4'b0101, word1 = 0xAABBCCDD; read → word1 = 0x22BB22DD, other words unchanged.
- READ_LATENCY=3: four back-to-back reads of sets 0..3 → four consecutive rsp_valid cycles in order, first in the cycle after edge E+2.
- Set 70 with N_SETS=64: write dropped (set 6 unchanged); read returns rsp_valid=1, rdata=0.
- nRST pulsed while two reads are in flight: no rsp_valid; INIT reruns for 64 cycles; prior data reads back as 0.
